// File: rtl/conv_line_feeder.sv
// conv_line_feeder
// Operand sequencer for convolution_first_line. Holds a TAPS-deep register
// file of (pixel, weight) pairs and, on a start pulse, streams one pair per
// clock onto o_x/o_w, then drives PIPE_LAT zero-operand drain cycles and
// finishes with a one-cycle o_done pulse. The partial-sum seed rides along
// with the first issued tap only.
//
// Optional feature macro: CONV_FEEDER_REVERSE_EN
//   defined   -> taps issue len-1 down to 0 (kernel flip); seed on tap len-1
//   undefined -> taps issue 0 up to len-1
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_wr_en/addr/x/w    tap write port (accepted in IDLE only, addr < TAPS)
//   i_psum_init         seed partial sum, captured at start
//   i_len               requested tap count (clamped to TAPS)
//   i_start             start pulse (IDLE only)
//   o_x, o_w, o_psum    operands to the convolution line (0 unless o_valid)
//   o_valid             a real tap is on o_x/o_w
//   o_busy              sequence in progress (ISSUE and FLUSH)
//   o_done              one-cycle completion pulse
module conv_line_feeder #(
  parameter int I_X      = 8,
  parameter int I_W      = 8,
  parameter int I_PSUM   = 16,
  parameter int TAPS     = 7,
  parameter int TAP_W    = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [TAP_W-1:0]  i_wr_addr,
  input  logic [I_X-1:0]    i_wr_x,
  input  logic [I_W-1:0]    i_wr_w,
  input  logic [I_PSUM-1:0] i_psum_init,
  input  logic [TAP_W:0]    i_len,
  input  logic              i_start,
  output logic [I_X-1:0]    o_x,
  output logic [I_W-1:0]    o_w,
  output logic [I_PSUM-1:0] o_psum,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [TAP_W:0] LEN_MAX = (TAP_W+1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_t;

  state_t               r_state;
  logic [I_X-1:0]       r_tap_x [TAPS];
  logic [I_W-1:0]       r_tap_w [TAPS];
  logic [TAP_W:0]       r_len;
  logic [TAP_W:0]       r_cnt;
  logic [DRAIN_W-1:0]   r_drain;

  logic [TAP_W:0]       w_len_eff;
  logic                 w_wr_ok;
  logic                 w_start;
  logic [TAP_W-1:0]     w_first_idx;
  logic [TAP_W-1:0]     w_next_idx;
  logic                 w_fwd;
  logic [I_X-1:0]       w_first_x;
  logic [I_W-1:0]       w_first_w;

  always_comb begin
    w_len_eff = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    w_wr_ok   = i_wr_en && (r_state == S_IDLE) && ({1'b0, i_wr_addr} < LEN_MAX);
    // o_done still high in IDLE only after a zero-length run; holding off
    // start for that cycle keeps the restart point one cycle after o_done.
    w_start   = i_start && (r_state == S_IDLE) && !o_done;
`ifdef CONV_FEEDER_REVERSE_EN
    w_first_idx = (w_len_eff == '0) ? '0 : TAP_W'(w_len_eff - 1'b1);
    w_next_idx  = TAP_W'(r_len - 1'b1 - r_cnt);
`else
    w_first_idx = '0;
    w_next_idx  = TAP_W'(r_cnt);
`endif
    // A write landing in the start cycle must be visible to the first tap.
    w_fwd     = w_wr_ok && (i_wr_addr == w_first_idx);
    w_first_x = w_fwd ? i_wr_x : r_tap_x[w_first_idx];
    w_first_w = w_fwd ? i_wr_w : r_tap_w[w_first_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_tap_x[i] <= '0;
        r_tap_w[i] <= '0;
      end
      r_len   <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      o_x     <= '0;
      o_w     <= '0;
      o_psum  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_tap_x[i_wr_addr] <= i_wr_x;
        r_tap_w[i_wr_addr] <= i_wr_w;
      end

      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (w_start) begin
            r_len <= w_len_eff;
            if (w_len_eff != '0) begin
              r_state <= S_ISSUE;
              r_cnt   <= (TAP_W+1)'(1);
              o_x     <= w_first_x;
              o_w     <= w_first_w;
              o_psum  <= i_psum_init;
              o_valid <= 1'b1;
              o_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_ISSUE: begin
          o_psum <= '0;
          if (r_cnt == r_len) begin
            r_state <= S_FLUSH;
            r_drain <= DRAIN_W'(1);
            o_x     <= '0;
            o_w     <= '0;
            o_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            o_x   <= r_tap_x[w_next_idx];
            o_w   <= r_tap_w[w_next_idx];
          end
        end

        S_FLUSH: begin
          if (r_drain == DRAIN_W'(PIPE_LAT)) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          // After FLUSH the pulse is already up and is dropped here; after a
          // zero-length start it is raised here, one edge later.
          o_done  <= !o_done;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_line_feeder.sv
module tb_conv_line_feeder;

  localparam int PIPE_LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wr_en;
  logic [2:0]  i_wr_addr;
  logic [7:0]  i_wr_x;
  logic [7:0]  i_wr_w;
  logic [15:0] i_psum_init;
  logic [3:0]  i_len;
  logic        i_start;
  logic [7:0]  o_x;
  logic [7:0]  o_w;
  logic [15:0] o_psum;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;

  always #5 i_clk = ~i_clk;

  conv_line_feeder #(
    .I_X(8), .I_W(8), .I_PSUM(16), .TAPS(7), .TAP_W(3), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_x(i_wr_x), .i_wr_w(i_wr_w),
    .i_psum_init(i_psum_init), .i_len(i_len), .i_start(i_start),
    .o_x(o_x), .o_w(o_w), .o_psum(o_psum),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );

  int nvec = 0;
  int nerr = 0;
  logic [7:0] ex_x [7];
  logic [7:0] ex_w [7];
  bit zero_taps = 1'b0;
`ifdef CONV_FEEDER_REVERSE_EN
  bit rev = 1'b1;
`else
  bit rev = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_chk(input string tag, input logic busy, input logic done);
    chk({tag, ".valid"}, 32'(o_valid), 32'(0));
    chk({tag, ".x"},     32'(o_x),     32'(0));
    chk({tag, ".w"},     32'(o_w),     32'(0));
    chk({tag, ".psum"},  32'(o_psum),  32'(0));
    chk({tag, ".busy"},  32'(o_busy),  32'(busy));
    chk({tag, ".done"},  32'(o_done),  32'(done));
  endtask

  task automatic write_tap(input logic [2:0] a, input logic [7:0] x, input logic [7:0] w);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_x = x; i_wr_w = w;
    @(posedge i_clk);
    #1 i_wr_en = 1'b0;
  endtask

  // Start a run and check every cycle through the cycle after o_done.
  // poke_at >= 0: at that tap, write tap 2 = (-1,-1) and pulse start.
  // wr0: write tap 0 = (ex_x[0], ex_w[0]) in the start cycle itself.
  task automatic run(input string tag, input logic [3:0] len, input logic [15:0] seed,
                     input int n, input int poke_at, input bit wr0);
    int idx;
    logic [7:0] ex, ew;
    @(negedge i_clk);
    i_len = len; i_psum_init = seed; i_start = 1'b1;
    if (wr0) begin
      i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_x = ex_x[0]; i_wr_w = ex_w[0];
    end
    @(posedge i_clk);
    #1 i_start = 1'b0; i_wr_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      idx = rev ? (n - 1 - k) : k;
      ex = zero_taps ? 8'h00 : ex_x[idx];
      ew = zero_taps ? 8'h00 : ex_w[idx];
      chk($sformatf("%s.valid[%0d]", tag, k), 32'(o_valid), 32'(1));
      chk($sformatf("%s.x[%0d]", tag, k),     32'(o_x),     32'(ex));
      chk($sformatf("%s.w[%0d]", tag, k),     32'(o_w),     32'(ew));
      chk($sformatf("%s.psum[%0d]", tag, k),  32'(o_psum),  (k == 0) ? 32'(seed) : 32'(0));
      chk($sformatf("%s.busy[%0d]", tag, k),  32'(o_busy),  32'(1));
      chk($sformatf("%s.done[%0d]", tag, k),  32'(o_done),  32'(0));
      if (k == poke_at) begin
        i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_x = 8'hFF; i_wr_w = 8'hFF; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_wr_en = 1'b0; i_start = 1'b0;
      end
    end
    for (int d = 0; d < PIPE_LAT; d++) begin
      @(negedge i_clk);
      quiet_chk($sformatf("%s.drain%0d", tag, d), 1'b1, 1'b0);
    end
    @(negedge i_clk);
    quiet_chk({tag, ".done"}, 1'b0, 1'b1);
    @(negedge i_clk);
    quiet_chk({tag, ".after"}, 1'b0, 1'b0);
  endtask

  initial begin
    ex_x[0] = 8'd100; ex_w[0] = 8'd50;
    ex_x[1] = 8'd10;  ex_w[1] = 8'd5;
    ex_x[2] = 8'd100; ex_w[2] = 8'd15;
    ex_x[3] = 8'd20;  ex_w[3] = 8'd50;
    ex_x[4] = 8'd100; ex_w[4] = 8'd50;
    ex_x[5] = 8'd10;  ex_w[5] = 8'd40;
    ex_x[6] = 8'd16;  ex_w[6] = 8'd5;
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_x = '0; i_wr_w = '0;
    i_psum_init = '0; i_len = '0; i_start = 1'b0;

    // reset state
    #12;
    quiet_chk("reset", 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // load taps; write to out-of-range address must be harmless
    for (int t = 0; t < 7; t++) write_tap(3'(t), ex_x[t], ex_w[t]);
    write_tap(3'd7, 8'hAA, 8'hBB);

    // basic sequence
    run("basic", 4'd7, 16'h0000, 7, -1, 1'b0);
    // seed and length clamp (-300)
    run("seed", 4'd9, 16'hFED4, 7, -1, 1'b0);

    // length zero
    @(negedge i_clk);
    i_len = 4'd0; i_psum_init = 16'h1234; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    quiet_chk("len0.e0", 1'b0, 1'b0);
    @(negedge i_clk);
    quiet_chk("len0.e1", 1'b0, 1'b1);
    @(negedge i_clk);
    quiet_chk("len0.e2", 1'b0, 1'b0);

    // write and start during ISSUE are ignored; tap 2 keeps its value
    run("busyctl", 4'd7, 16'h0000, 7, 1, 1'b0);
    run("rerun", 4'd7, 16'h0000, 7, -1, 1'b0);

    // write in the start cycle is seen by the issued tap
    ex_x[0] = 8'd7; ex_w[0] = 8'hFD;
    run("wrstart", 4'd1, 16'h0011, 1, -1, 1'b1);

    // reset mid-sequence at tap 3
    @(negedge i_clk);
    i_len = 4'd7; i_psum_init = 16'h0000; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk($sformatf("rstmid.valid[%0d]", k), 32'(o_valid), 32'(1));
    end
    chk("rstmid.x3", 32'(o_x), rev ? 32'(ex_x[3]) : 32'(ex_x[3]));
    #1 i_rst_n = 1'b0;
    #1 quiet_chk("rstmid", 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // restart without reload: all pairs are zero, seed still carried
    zero_taps = 1'b1;
    run("zeros", 4'd7, 16'h0005, 7, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
